// File: rtl/ls_pkg.sv
// Shared definitions for the load/store unit: access-size encoding, FSM states
// and the alignment helpers used when a request is accepted.
package ls_pkg;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;
    localparam logic [1:0] SIZE_D = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RD   = 2'b01,
        WR   = 2'b10,
        RESP = 2'b11
    } ls_state_e;

    // wide = 1 when the memory word is 64 bits; a dword is illegal otherwise
    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [2:0] addr_lo,
                                           input logic       wide);
        logic mis;
        case (size)
            SIZE_B:  mis = 1'b0;
            SIZE_H:  mis = addr_lo[0];
            SIZE_W:  mis = (addr_lo[1:0] != 2'b00);
            SIZE_D:  mis = (!wide) || (addr_lo != 3'b000);
            default: mis = 1'b1;
        endcase
        return mis;
    endfunction

    function automatic logic is_full_width(input logic [1:0] size,
                                           input logic       wide);
        return wide ? (size == SIZE_D) : (size == SIZE_W);
    endfunction

endpackage

// File: rtl/ls_lane_align.sv
// Combinational byte-lane logic: merges store bytes into a read word and
// extracts/extends a load field down to bit 0 (little-endian lanes).
module ls_lane_align
    import ls_pkg::*;
#(
    parameter  int DATA_W = 32,
    localparam int OFF_W  = $clog2(DATA_W / 8)
) (
    input  logic [1:0]        size_i,
    input  logic [OFF_W-1:0]  off_i,
    input  logic              signed_i,
    input  logic [DATA_W-1:0] word_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] merged_o,
    output logic [DATA_W-1:0] load_o
);

    localparam int NLANES = DATA_W / 8;

    logic [7:0]        base_s;
    logic [NLANES-1:0] field_s;
    logic [NLANES-1:0] mask_s;
    logic [OFF_W+2:0]  bitoff_s;
    logic [DATA_W-1:0] shifted_s;
    logic [DATA_W-1:0] wshift_s;
    logic              sign_s;

    assign bitoff_s  = {off_i, 3'b000};
    assign shifted_s = word_i >> bitoff_s;
    assign wshift_s  = wdata_i << bitoff_s;
    assign field_s   = base_s[NLANES-1:0];
    assign mask_s    = field_s << off_i;

    // Lane pattern of the access at offset 0 and the sign bit of the field
    always_comb begin
        base_s = 8'h01;
        sign_s = 1'b0;
        case (size_i)
            SIZE_B: begin
                base_s = 8'h01;
                sign_s = signed_i & shifted_s[7];
            end
            SIZE_H: begin
                base_s = 8'h03;
                sign_s = signed_i & shifted_s[15];
            end
            SIZE_W: begin
                base_s = 8'h0F;
                sign_s = signed_i & shifted_s[31];
            end
            SIZE_D: begin
                base_s = 8'hFF;
                sign_s = signed_i & shifted_s[DATA_W-1];
            end
            default: begin
                base_s = 8'h01;
                sign_s = 1'b0;
            end
        endcase
    end

    // Per-lane select for both the store merge and the load extension
    always_comb begin
        merged_o = word_i;
        load_o   = shifted_s;
        for (int k = 0; k < NLANES; k++) begin
            merged_o[8*k +: 8] = mask_s[k]  ? wshift_s[8*k +: 8]  : word_i[8*k +: 8];
            load_o[8*k +: 8]   = field_s[k] ? shifted_s[8*k +: 8] : {8{sign_s}};
        end
    end

endmodule

// File: rtl/ls_unit.sv
// Load/store unit: accepts one request at a time, performs read, write or
// read-modify-write against a word-wide memory port, returns one response.
module ls_unit
    import ls_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err
);

    localparam int   OFF_W = $clog2(DATA_W / 8);
    localparam logic WIDE  = (DATA_W == 64);

    ls_state_e         state_q, state_d;
    logic              ready_q;
    logic              store_q;
    logic              signed_q;
    logic [1:0]        size_q;
    logic [OFF_W-1:0]  off_q;
    logic [DATA_W-1:0] wdata_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic              mem_rd_q;
    logic              mem_wr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              resp_valid_q;
    logic [DATA_W-1:0] resp_rdata_q;
    logic              resp_err_q;

    logic              accept_s;
    logic              misalign_s;
    logic              full_s;
    logic [DATA_W-1:0] merged_s;
    logic [DATA_W-1:0] load_s;

    // ready_q is low through reset, so it alone gates the handshake
    assign accept_s   = req_valid & ready_q & (state_q == IDLE);
    assign misalign_s = is_misaligned(req_size, req_addr[2:0], WIDE);
    assign full_s     = is_full_width(req_size, WIDE);

    // Lane logic works on the latched request and the live read data
    ls_lane_align #(.DATA_W(DATA_W)) u_align (
        .size_i   (size_q),
        .off_i    (off_q),
        .signed_i (signed_q),
        .word_i   (mem_rdata),
        .wdata_i  (wdata_q),
        .merged_o (merged_s),
        .load_o   (load_s)
    );

    // Next-state decode
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (!accept_s)                 state_d = IDLE;
                else if (misalign_s)           state_d = RESP;
                else if (req_store && full_s)  state_d = WR;
                else                           state_d = RD;
            end
            RD: begin
                if (!mem_ready)    state_d = RD;
                else if (store_q)  state_d = WR;
                else               state_d = RESP;
            end
            WR: begin
                if (mem_ready) state_d = RESP;
                else           state_d = WR;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, request latch and registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            ready_q      <= 1'b0;
            store_q      <= 1'b0;
            signed_q     <= 1'b0;
            size_q       <= 2'b00;
            off_q        <= '0;
            wdata_q      <= '0;
            mem_addr_q   <= '0;
            mem_rd_q     <= 1'b0;
            mem_wr_q     <= 1'b0;
            mem_wdata_q  <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            ready_q      <= (state_d == IDLE);
            mem_rd_q     <= (state_d == RD);
            mem_wr_q     <= (state_d == WR);
            resp_valid_q <= (state_d == RESP);

            if (accept_s) begin
                store_q    <= req_store;
                signed_q   <= req_signed;
                size_q     <= req_size;
                off_q      <= req_addr[OFF_W-1:0];
                wdata_q    <= req_wdata;
                mem_addr_q <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                if (req_store && full_s) begin
                    mem_wdata_q <= req_wdata;
                end
            end else if ((state_q == RD) && mem_ready && store_q) begin
                mem_wdata_q <= merged_s;
            end

            // Response fields are only non-zero while resp_valid is high
            if ((state_d == RESP) && (state_q == IDLE)) begin
                resp_rdata_q <= '0;
                resp_err_q   <= 1'b1;
            end else if ((state_d == RESP) && (state_q == RD)) begin
                resp_rdata_q <= load_s;
                resp_err_q   <= 1'b0;
            end else begin
                resp_rdata_q <= '0;
                resp_err_q   <= 1'b0;
            end
        end
    end

    assign req_ready  = ready_q;
    assign mem_addr   = mem_addr_q;
    assign mem_rd     = mem_rd_q;
    assign mem_wr     = mem_wr_q;
    assign mem_wdata  = mem_wdata_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_ls_unit.sv
// Directed scoreboard bench for ls_unit: a 32-bit and a 64-bit instance share
// one stimulus path; use64 selects which one is driven and observed.
module tb_ls_unit;

    logic        clock;
    logic        reset;
    logic        req_valid;
    logic        req_store;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [63:0] req_wdata;
    logic [63:0] mem_rdata;
    logic        mem_ready;
    logic        use64;

    logic        v32_in, v64_in;
    logic        r32, r64;
    logic [31:0] a32, a64;
    logic        rd32, rd64, wr32, wr64;
    logic [31:0] wd32;
    logic [63:0] wd64;
    logic        rv32, rv64, re32, re64;
    logic [31:0] rr32;
    logic [63:0] rr64;

    logic        s_ready, s_rd, s_wr, s_valid, s_err;
    logic [31:0] s_addr;
    logic [63:0] s_wdata, s_rdata;

    typedef struct packed {
        logic [63:0] rdata;
        logic        err;
    } resp_t;

    resp_t exp_q[$];
    int    tests;
    int    fails;

    assign v32_in = req_valid & ~use64;
    assign v64_in = req_valid & use64;

    ls_unit #(.DATA_W(32), .ADDR_W(32)) dut32 (
        .clock(clock), .reset(reset),
        .req_valid(v32_in), .req_ready(r32), .req_store(req_store),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata[31:0]),
        .mem_addr(a32), .mem_rd(rd32), .mem_wr(wr32), .mem_wdata(wd32),
        .mem_rdata(mem_rdata[31:0]), .mem_ready(mem_ready),
        .resp_valid(rv32), .resp_rdata(rr32), .resp_err(re32)
    );

    ls_unit #(.DATA_W(64), .ADDR_W(32)) dut64 (
        .clock(clock), .reset(reset),
        .req_valid(v64_in), .req_ready(r64), .req_store(req_store),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .mem_addr(a64), .mem_rd(rd64), .mem_wr(wr64), .mem_wdata(wd64),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .resp_valid(rv64), .resp_rdata(rr64), .resp_err(re64)
    );

    assign s_ready = use64 ? r64  : r32;
    assign s_addr  = use64 ? a64  : a32;
    assign s_rd    = use64 ? rd64 : rd32;
    assign s_wr    = use64 ? wr64 : wr32;
    assign s_wdata = use64 ? wd64 : {32'h0, wd32};
    assign s_valid = use64 ? rv64 : rv32;
    assign s_rdata = use64 ? rr64 : {32'h0, rr32};
    assign s_err   = use64 ? re64 : re32;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One request end to end; the memory side answers after dly strobe cycles
    task automatic run_op(input string tag, input bit w64, input logic st,
                          input logic [1:0] sz, input logic sg,
                          input logic [31:0] addr, input logic [63:0] wd,
                          input logic [63:0] old, input int dly,
                          input logic [63:0] exp_rdata, input logic exp_err,
                          input int exp_rd, input int exp_wr,
                          input logic [63:0] exp_wdata, input logic [31:0] exp_addr,
                          input int exp_lat);
        int          rd_n, wr_n, lat, cnt, cur, prev;
        bit          overlap, unstable, got;
        logic [63:0] wd_first;
        resp_t       r;
        rd_n = 0; wr_n = 0; lat = 0; cnt = 0; prev = 0;
        overlap = 1'b0; unstable = 1'b0; got = 1'b0; wd_first = 64'h0;
        use64 = w64;
        @(negedge clock);
        chk({tag, ":ready_before"}, {63'h0, s_ready}, 64'h1);
        req_valid = 1'b1; req_store = st; req_size = sz; req_signed = sg;
        req_addr = addr; req_wdata = wd; mem_rdata = old; mem_ready = 1'b0;
        exp_q.push_back('{exp_rdata, exp_err});
        for (int k = 1; k <= 40 && !got; k++) begin
            @(negedge clock);
            req_valid = 1'b0;
            if (s_rd && s_wr) overlap = 1'b1;
            if ((s_rd || s_wr) && (s_addr !== exp_addr)) unstable = 1'b1;
            if (s_rd) rd_n++;
            if (s_wr) begin
                wr_n++;
                if (wr_n == 1) wd_first = s_wdata;
                else if (s_wdata !== wd_first) unstable = 1'b1;
            end
            if (s_valid) begin
                got = 1'b1;
                lat = k + 1;
                chk({tag, ":sb_nonempty"}, {63'h0, exp_q.size() > 0}, 64'h1);
                if (exp_q.size() > 0) begin
                    r = exp_q.pop_front();
                    chk({tag, ":rdata"}, s_rdata, r.rdata);
                    chk({tag, ":err"}, {63'h0, s_err}, {63'h0, r.err});
                end
            end
            cur = s_wr ? 2 : (s_rd ? 1 : 0);
            if (cur != 0) begin
                cnt = (cur == prev) ? cnt + 1 : 1;
                mem_ready = (cnt > dly);
            end else begin
                cnt = 0;
                mem_ready = 1'b0;
            end
            prev = cur;
        end
        chk({tag, ":resp_seen"}, {63'h0, got}, 64'h1);
        chk({tag, ":latency"}, 64'(lat), 64'(exp_lat));
        chk({tag, ":rd_cycles"}, 64'(rd_n), 64'(exp_rd));
        chk({tag, ":wr_cycles"}, 64'(wr_n), 64'(exp_wr));
        if (exp_wr > 0) chk({tag, ":wdata"}, wd_first, exp_wdata);
        chk({tag, ":rd_wr_overlap"}, {63'h0, overlap}, 64'h0);
        chk({tag, ":addr_wdata_stable"}, {63'h0, unstable}, 64'h0);
        @(negedge clock);
        mem_ready = 1'b0;
        chk({tag, ":single_pulse"}, {63'h0, s_valid}, 64'h0);
        chk({tag, ":ready_after"}, {63'h0, s_ready}, 64'h1);
    endtask

    initial begin
        bit seen;
        tests = 0; fails = 0;
        reset = 1'b1; use64 = 1'b0;
        req_valid = 1'b0; req_store = 1'b0; req_size = 2'b00; req_signed = 1'b0;
        req_addr = 32'h0; req_wdata = 64'h0; mem_rdata = 64'h0; mem_ready = 1'b0;

        repeat (3) @(negedge clock);
        chk("rst:ready32", {63'h0, r32}, 64'h0);
        chk("rst:ready64", {63'h0, r64}, 64'h0);
        chk("rst:strobes", {62'h0, rd32 | rd64, wr32 | wr64}, 64'h0);
        chk("rst:resp", {62'h0, rv32 | rv64, re32 | re64}, 64'h0);
        chk("rst:addr_data", {a32, wd32}, 64'h0);
        chk("rst:rdata", rr64 | {32'h0, rr32}, 64'h0);
        reset = 1'b0;
        @(negedge clock);
        chk("rst:ready_release", {62'h0, r32, r64}, 64'h3);

        //      tag        w64   st    size   sg    addr          wdata                  old word               dly exp_rdata              err   rd wr exp_wdata              exp_addr      lat
        run_op("ldb_s",    1'b0, 1'b0, 2'b00, 1'b1, 32'h0000_0103, 64'h0,                 64'h8011_2233,         0, 64'hFFFF_FF80,          1'b0, 1, 0, 64'h0,                 32'h0000_0100, 3);
        run_op("sth_rmw",  1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0202, 64'hABCD,              64'h1122_3344,         0, 64'h0,                  1'b0, 1, 1, 64'hABCD_3344,         32'h0000_0200, 4);
        run_op("ldw_mis",  1'b0, 1'b0, 2'b10, 1'b0, 32'h0000_0301, 64'h0,                 64'h5555_5555,         0, 64'h0,                  1'b1, 0, 0, 64'h0,                 32'h0000_0300, 2);
        run_op("stw_slow", 1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0400, 64'hDEAD_BEEF,         64'h0,                 3, 64'h0,                  1'b0, 0, 4, 64'hDEAD_BEEF,         32'h0000_0400, 6);
        run_op("ldh_u",    1'b0, 1'b0, 2'b01, 1'b0, 32'h0000_0106, 64'h0,                 64'h8011_2233,         0, 64'h0000_8011,          1'b0, 1, 0, 64'h0,                 32'h0000_0104, 3);
        run_op("ldh_s",    1'b0, 1'b0, 2'b01, 1'b1, 32'h0000_0106, 64'h0,                 64'h8011_2233,         0, 64'hFFFF_8011,          1'b0, 1, 0, 64'h0,                 32'h0000_0104, 3);
        run_op("stb_rmw",  1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_0501, 64'h1234_5677,         64'hAABB_CCDD,         0, 64'h0,                  1'b0, 1, 1, 64'hAABB_77DD,         32'h0000_0500, 4);
        run_op("ldd_on32", 1'b0, 1'b0, 2'b11, 1'b0, 32'h0000_0000, 64'h0,                 64'h0,                 0, 64'h0,                  1'b1, 0, 0, 64'h0,                 32'h0000_0000, 2);
        run_op("ldw_slow", 1'b0, 1'b0, 2'b10, 1'b0, 32'h0000_0104, 64'h0,                 64'h0123_4567,         2, 64'h0123_4567,          1'b0, 3, 0, 64'h0,                 32'h0000_0104, 5);
        run_op("sth_mis",  1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0203, 64'hFFFF,              64'h0,                 0, 64'h0,                  1'b1, 0, 0, 64'h0,                 32'h0000_0200, 2);
        run_op("w64_ldh",  1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_0006, 64'h0,                 64'h8001_0000_0000_0000, 0, 64'h8001,             1'b0, 1, 0, 64'h0,                 32'h0000_0000, 3);
        run_op("w64_std",  1'b1, 1'b1, 2'b11, 1'b0, 32'h0000_0010, 64'h1122_3344_5566_7788, 64'h0,               0, 64'h0,                  1'b0, 0, 1, 64'h1122_3344_5566_7788, 32'h0000_0010, 3);
        run_op("w64_stw",  1'b1, 1'b1, 2'b10, 1'b0, 32'h0000_0014, 64'hCAFE_F00D,         64'h0123_4567_89AB_CDEF, 0, 64'h0,                1'b0, 1, 1, 64'hCAFE_F00D_89AB_CDEF, 32'h0000_0010, 4);
        run_op("w64_ldw_s",1'b1, 1'b0, 2'b10, 1'b1, 32'h0000_0004, 64'h0,                 64'h8000_0001_0000_0000, 0, 64'hFFFF_FFFF_8000_0001, 1'b0, 1, 0, 64'h0,               32'h0000_0000, 3);

        // Reset while a load is waiting in RD abandons it without a response
        use64 = 1'b0;
        @(negedge clock);
        req_valid = 1'b1; req_store = 1'b0; req_size = 2'b10; req_signed = 1'b0;
        req_addr = 32'h0000_0100; mem_ready = 1'b0;
        @(negedge clock);
        req_valid = 1'b0;
        chk("rstrd:in_rd", {63'h0, s_rd}, 64'h1);
        reset = 1'b1;
        @(negedge clock);
        chk("rstrd:rd_dropped", {63'h0, s_rd}, 64'h0);
        chk("rstrd:ready_low", {63'h0, s_ready}, 64'h0);
        chk("rstrd:no_resp", {63'h0, s_valid}, 64'h0);
        reset = 1'b0;
        @(negedge clock);
        chk("rstrd:ready_high", {63'h0, s_ready}, 64'h1);
        seen = 1'b0;
        repeat (4) begin
            @(negedge clock);
            if (s_valid || s_rd) seen = 1'b1;
        end
        chk("rstrd:quiet", {63'h0, seen}, 64'h0);
        chk("sb:drained", 64'(exp_q.size()), 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ls_unit.md
LS_UNIT -- requirements
Module: ls_unit

Interface
REQ-001 Parameter DATA_W, default 32, memory word width in bits; legal values 32 or 64.
REQ-002 Parameter ADDR_W, default 32, byte-address width.
REQ-003 Derived constant OFF_W = log2(DATA_W/8), the byte-offset bits within a word.
REQ-004 clock  in  1  rising-edge clock.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 req_valid  in  1  request present.
REQ-007 req_ready  out  1  unit accepts a request this cycle.
REQ-008 req_store  in  1  1 = store, 0 = load.
REQ-009 req_size  in  2  00 byte, 01 half, 10 word(32), 11 dword(64).
REQ-010 req_signed  in  1  load sign-extends when 1, zero-extends when 0.
REQ-011 req_addr  in  ADDR_W  byte address.
REQ-012 req_wdata  in  DATA_W  store data, right-justified.
REQ-013 mem_addr  out  ADDR_W  word-aligned address, low OFF_W bits forced to 0.
REQ-014 mem_rd / mem_wr  out  1 each  memory read / write strobe.
REQ-015 mem_wdata  out  DATA_W; mem_rdata  in  DATA_W; mem_ready  in  1  access complete.
REQ-016 resp_valid  out  1; resp_rdata  out  DATA_W; resp_err  out  1.

Function
REQ-017 Byte lanes are little-endian: offset k occupies bits 8k+7:8k.
REQ-018 FSM states IDLE, RD, WR, RESP; req_ready = 1 only in IDLE.
REQ-019 Handshake req_valid & req_ready latches all req_* fields; unit ignores req_* otherwise.
REQ-020 Misaligned: half with addr[0]=1, word with addr[1:0]!=0, dword with addr[2:0]!=0, or size 11 when DATA_W=32 -> IDLE to RESP with resp_err=1, resp_rdata=0, no mem strobe.
REQ-021 Load: IDLE -> RD; mem_rd held high until mem_ready; rdata captured on the mem_ready cycle; -> RESP.
REQ-022 Full-width store (size equals DATA_W): IDLE -> WR; mem_wdata = req_wdata.
REQ-023 Sub-word store: IDLE -> RD (read) -> WR; mem_wdata = captured word with the addressed lanes replaced by the low bytes of req_wdata, other lanes unchanged.
REQ-024 WR holds mem_wr and mem_wdata stable until mem_ready, then -> RESP.
REQ-025 mem_addr is stable throughout RD and WR; mem_rd and mem_wr are never high together.
REQ-026 Load result = addressed field shifted to bit 0, extended to DATA_W by req_signed; store response resp_rdata = 0.
REQ-027 RESP asserts resp_valid for exactly one cycle, then -> IDLE; the next request is accepted no earlier than the following cycle.
REQ-028 Minimum latency with mem_ready tied to 1: load 3 cycles accept-to-resp_valid, sub-word store 4, full store 3, error 2.

Reset
REQ-029 reset in any state, including mid-RD/WR, forces IDLE on the next edge and abandons the access.
REQ-030 During reset all outputs are 0 except req_ready, which is 0 while reset is asserted and 1 in the first cycle after reset is released.

Structure
REQ-031 Package ls_pkg holds the size encoding constants and the state enum.
REQ-032 One combinational sub-module, ls_lane_align, contains the lane merge (store) and extract/extend (load) logic; the FSM and registers live in ls_unit.

Verification
REQ-033 Load byte signed, addr 0x103, mem_rdata 0x80112233 -> resp_rdata 0xFFFFFF80, err 0.
REQ-034 Store half, addr 0x202, wdata 0xABCD, old word 0x11223344 -> one read, then write 0xABCD3344 to 0x200.
REQ-035 Load word, addr 0x301 -> resp_err 1 after 2 cycles, mem_rd/mem_wr never high.
REQ-036 Store word with mem_ready delayed 3 cycles -> mem_wr/mem_wdata stable for 4 cycles, single resp_valid pulse.
REQ-037 reset asserted while in RD -> IDLE next cycle, mem_rd 0, no resp_valid.
REQ-038 DATA_W=64: load half unsigned, addr 0x6, rdata 0x8001_0000_0000_0000 -> resp_rdata 0x8001.
